// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter
//   Shares one fixed-latency pipelined integer multiplier between the two
//   issue pipes. It arbitrates round-robin on contention, does the issue
//   handshake, freezes on writeback stall, flushes in-flight work, and tags
//   each result with its destination register and owning pipe.
//
// Ports
//   clk_i, rst_i                clock, synchronous active-high reset
//   reqN_valid/opcode/ra/rb/rd  pipe N multiply request (N = 0,1)
//   reqN_ready_o                pipe N request accepted this cycle
//   stall_i                     writeback stall; freezes tracking + multiplier
//   flush_i                     kill all in-flight and requesting operations
//   mul_valid/opcode/ra/rb_o    issue port to the multiplier
//   mul_hold_o                  multiplier pipeline freeze
//   mul_result_i                multiplier result, aligned with tracking tail
//   wb_valid/value/rd/port_o    tagged writeback
//   pending_rd_mask_o           one bit per rd with a result in flight
//   busy_count_o                number of valid in-flight operations
//
// MUL_LATENCY is legal in 1..4, and CNT_W must satisfy 2^CNT_W > MUL_LATENCY.
module mul_issue_arbiter #(
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic [31:0]      req0_opcode_i,
  input  logic [31:0]      req0_ra_i,
  input  logic [31:0]      req0_rb_i,
  input  logic [4:0]       req0_rd_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [31:0]      req1_opcode_i,
  input  logic [31:0]      req1_ra_i,
  input  logic [31:0]      req1_rb_i,
  input  logic [4:0]       req1_rd_i,
  output logic             req1_ready_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             mul_valid_o,
  output logic [31:0]      mul_opcode_o,
  output logic [31:0]      mul_ra_o,
  output logic [31:0]      mul_rb_o,
  output logic             mul_hold_o,
  input  logic [31:0]      mul_result_i,
  output logic             wb_valid_o,
  output logic [31:0]      wb_value_o,
  output logic [4:0]       wb_rd_o,
  output logic             wb_port_o,
  output logic [31:0]      pending_rd_mask_o,
  output logic [CNT_W-1:0] busy_count_o
);

  localparam int L = MUL_LATENCY;

  // Tracking pipeline, one entry per multiplier stage; entry L-1 lines up
  // with mul_result_i.
  logic [L-1:0]      r_vld_pipe;
  logic [L-1:0][4:0] r_rd_pipe;
  logic [L-1:0]      r_port_pipe;
  logic              r_rr_ptr;

  logic              w_contested;
  logic              w_grant_any;
  logic              w_gsel;
  logic              w_issue;
  logic [31:0]       w_opcode;
  logic [4:0]        w_rd;
  logic [31:0]       w_mask;
  logic [CNT_W-1:0]  w_cnt;

  // Grant: a lone requester wins; on contention rr_ptr names the winner.
  // With no request w_gsel is 0, so the operand mux falls back to pipe 0.
  assign w_contested = req0_valid_i & req1_valid_i;
  assign w_grant_any = req0_valid_i | req1_valid_i;
  assign w_gsel      = w_contested ? r_rr_ptr : req1_valid_i;
  // Reset also blocks issue so every handshake output is quiet during reset.
  assign w_issue     = w_grant_any & ~stall_i & ~flush_i & ~rst_i;

  assign req0_ready_o = w_issue & ~w_gsel;
  assign req1_ready_o = w_issue &  w_gsel;
  assign mul_valid_o  = w_issue;

  assign w_opcode = w_gsel ? req1_opcode_i : req0_opcode_i;
  assign w_rd     = w_gsel ? req1_rd_i     : req0_rd_i;

  // funct3[2] selects divide/remainder; clear it so only multiplies reach
  // the multiplier even if a requester misbehaves.
  assign mul_opcode_o = {w_opcode[31:15], 1'b0, w_opcode[13:0]};
  assign mul_ra_o     = w_gsel ? req1_ra_i : req0_ra_i;
  assign mul_rb_o     = w_gsel ? req1_rb_i : req0_rb_i;
  assign mul_hold_o   = stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe  <= '0;
      r_rd_pipe   <= '0;
      r_port_pipe <= '0;
      r_rr_ptr    <= 1'b0;
    end else begin
      if (flush_i) begin
        r_vld_pipe <= '0;
      end else if (!stall_i) begin
        r_vld_pipe[0]  <= w_issue;
        r_rd_pipe[0]   <= w_rd;
        r_port_pipe[0] <= w_gsel;
        for (int k = 1; k < L; k++) begin
          r_vld_pipe[k]  <= r_vld_pipe[k-1];
          r_rd_pipe[k]   <= r_rd_pipe[k-1];
          r_port_pipe[k] <= r_port_pipe[k-1];
        end
      end
      // Only a contested issue moves the pointer, to the pipe that lost.
      if (w_issue && w_contested)
        r_rr_ptr <= ~w_gsel;
    end
  end

  assign wb_valid_o = r_vld_pipe[L-1] & ~flush_i & ~rst_i;
  assign wb_value_o = mul_result_i;
  assign wb_rd_o    = r_rd_pipe[L-1];
  assign wb_port_o  = r_port_pipe[L-1];

  always_comb begin
    w_mask = '0;
    w_cnt  = '0;
    for (int k = 0; k < L; k++) begin
      if (r_vld_pipe[k])
        w_mask[r_rd_pipe[k]] = 1'b1;
      w_cnt = w_cnt + CNT_W'(r_vld_pipe[k]);
    end
    // x0 never carries a hazard.
    w_mask[0] = 1'b0;
  end

  assign pending_rd_mask_o = w_mask;
  assign busy_count_o      = w_cnt;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
module tb_mul_issue_arbiter;
  localparam int L     = 2;
  localparam int CNT_W = 3;

  typedef struct {
    bit          v;
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic        port;
    logic [31:0] val;
    int          due;
  } exp_t;

  logic clk = 0;
  logic rst_i = 1;
  logic req0_valid_i = 0, req1_valid_i = 0;
  logic [31:0] req0_opcode_i = 0, req0_ra_i = 0, req0_rb_i = 0;
  logic [31:0] req1_opcode_i = 0, req1_ra_i = 0, req1_rb_i = 0;
  logic [4:0]  req0_rd_i = 0, req1_rd_i = 0;
  logic req0_ready_o, req1_ready_o;
  logic stall_i = 0, flush_i = 0;
  logic mul_valid_o, mul_hold_o;
  logic [31:0] mul_opcode_o, mul_ra_o, mul_rb_o, mul_result_i;
  logic wb_valid_o, wb_port_o;
  logic [31:0] wb_value_o, pending_rd_mask_o;
  logic [4:0] wb_rd_o;
  logic [CNT_W-1:0] busy_count_o;

  int n_checks = 0;
  int n_errs   = 0;
  int acnt     = 0;   // count of completed non-stalled cycles
  bit prev_st  = 0;
  bit armed    = 0;
  bit m_rr     = 0;
  exp_t sbq[$];

  mul_issue_arbiter #(.MUL_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i),
    .req0_ra_i(req0_ra_i), .req0_rb_i(req0_rb_i), .req0_rd_i(req0_rd_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i),
    .req1_ra_i(req1_ra_i), .req1_rb_i(req1_rb_i), .req1_rd_i(req1_rd_i),
    .req1_ready_o(req1_ready_o),
    .stall_i(stall_i), .flush_i(flush_i),
    .mul_valid_o(mul_valid_o), .mul_opcode_o(mul_opcode_o),
    .mul_ra_o(mul_ra_o), .mul_rb_o(mul_rb_o), .mul_hold_o(mul_hold_o),
    .mul_result_i(mul_result_i),
    .wb_valid_o(wb_valid_o), .wb_value_o(wb_value_o), .wb_rd_o(wb_rd_o),
    .wb_port_o(wb_port_o), .pending_rd_mask_o(pending_rd_mask_o),
    .busy_count_o(busy_count_o)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension multiply semantics from funct3[1:0].
  function automatic logic [31:0] mres(input logic [31:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [1:0]  f;
    f  = op[13:12];
    ea = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Environment multiplier: fixed latency L, frozen by mul_hold_o.
  logic [31:0] env_pipe [L];
  always @(posedge clk) begin
    if (!mul_hold_o) begin
      env_pipe[0] <= mres(mul_opcode_o, mul_ra_o, mul_rb_o);
      for (int k = 1; k < L; k++) env_pipe[k] <= env_pipe[k-1];
    end
  end
  assign mul_result_i = env_pipe[L-1];

  function automatic req_t mk(input bit v, input int f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
    req_t r;
    r.v  = v;
    r.op = 32'h0200_0033 | (32'(f3) << 12) | (32'(rd) << 7);
    r.a  = a;
    r.b  = b;
    r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus: check registered state, drive, check issue.
  task automatic step(input req_t r0, input req_t r1, input bit st, input bit fl,
                      input bit rs);
    logic [31:0] em;
    bit gsel, iss;
    req_t g;
    @(posedge clk);
    #1;
    if (!prev_st) acnt++;
    if (armed) begin
      em = 0;
      foreach (sbq[i]) em[sbq[i].rd] = 1'b1;
      em[0] = 1'b0;
      chk("mask", pending_rd_mask_o, em);
      chk("busy", 32'(busy_count_o), 32'(sbq.size()));
    end
    req0_valid_i = r0.v; req0_opcode_i = r0.op; req0_ra_i = r0.a;
    req0_rb_i = r0.b; req0_rd_i = r0.rd;
    req1_valid_i = r1.v; req1_opcode_i = r1.op; req1_ra_i = r1.a;
    req1_rb_i = r1.b; req1_rd_i = r1.rd;
    stall_i = st; flush_i = fl; rst_i = rs;
    #2;
    gsel = (r0.v && r1.v) ? m_rr : r1.v;
    iss  = (r0.v || r1.v) && !st && !fl && !rs;
    g    = gsel ? r1 : r0;
    if (armed) begin
      chk("ready0", 32'(req0_ready_o), 32'(iss && !gsel));
      chk("ready1", 32'(req1_ready_o), 32'(iss && gsel));
      chk("mul_valid", 32'(mul_valid_o), 32'(iss));
      chk("mul_hold", 32'(mul_hold_o), 32'(st));
      if (iss) begin
        chk("mul_opcode", mul_opcode_o, g.op & ~32'h0000_4000);
        chk("mul_ra", mul_ra_o, g.a);
        chk("mul_rb", mul_rb_o, g.b);
      end
    end
    if (iss) begin
      sbq.push_back('{rd: g.rd, port: gsel, val: mres(g.op, g.a, g.b), due: acnt + L});
      if (r0.v && r1.v) m_rr = !gsel;
    end
    if (fl || rs) sbq.delete();
    if (rs) m_rr = 0;
    prev_st = st;
  endtask

  // Monitor: a result must appear exactly when the oldest op is due.
  always @(negedge clk) begin
    bit ev;
    if (armed) begin
      if (sbq.size() > 0 && sbq[0].due < acnt) begin
        n_checks++; n_errs++;
        $display("FAIL wb_missing rd=%0d port=%0d", sbq[0].rd, sbq[0].port);
        void'(sbq.pop_front());
      end
      ev = (sbq.size() > 0) && (sbq[0].due == acnt) && !flush_i && !rst_i;
      chk("wb_valid", 32'(wb_valid_o), 32'(ev));
      if (wb_valid_o && ev) begin
        chk("wb_rd", 32'(wb_rd_o), 32'(sbq[0].rd));
        chk("wb_port", 32'(wb_port_o), 32'(sbq[0].port));
        chk("wb_value", wb_value_o, sbq[0].val);
        if (!stall_i) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    req_t nil, r0, r1;
    bit st, fl, rs;
    nil = mk(0, 0, 0, 0, 0);

    // Reset state
    step(nil, nil, 0, 0, 1);
    armed = 1;
    step(nil, nil, 0, 0, 1);
    step(nil, nil, 0, 0, 0);
    chk("rst_busy", 32'(busy_count_o), 0);
    chk("rst_wbv", 32'(wb_valid_o), 0);
    chk("rst_mask", pending_rd_mask_o, 0);

    // Single issue: 7*6 -> rd5
    step(mk(1, 0, 7, 6, 5), nil, 0, 0, 0);
    chk("t1_rdy0", 32'(req0_ready_o), 1);
    step(nil, nil, 0, 0, 0);
    chk("t1_mask", pending_rd_mask_o, 32'h20);
    step(nil, nil, 0, 0, 0);
    chk("t1_wbv", 32'(wb_valid_o), 1);
    chk("t1_val", wb_value_o, 42);
    chk("t1_rd", 32'(wb_rd_o), 5);
    chk("t1_port", 32'(wb_port_o), 0);
    step(nil, nil, 0, 0, 0);
    chk("t1_mask0", pending_rd_mask_o, 0);

    // Contention: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 0, 32'(i + 1), 3, 1), mk(1, 0, 32'(i + 2), 5, 2), 0, 0, 0);
      chk("t2_gnt1", 32'(req1_ready_o), 32'(i % 2));
      if (i == 2) chk("t2_busy", 32'(busy_count_o), 2);
    end
    repeat (3) step(nil, nil, 0, 0, 0);

    // Stall: MULHU 0xFFFFFFFF*2 -> high word 1, held while stalled
    step(mk(1, 3, 32'hFFFF_FFFF, 2, 3), nil, 0, 0, 0);
    step(nil, nil, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 0, 1, 1, 7), nil, 1, 0, 0);
      chk("t3_nordy", 32'(req0_ready_o), 0);
      chk("t3_wbv", 32'(wb_valid_o), 1);
      chk("t3_val", wb_value_o, 1);
      chk("t3_rd", 32'(wb_rd_o), 3);
    end
    repeat (3) step(nil, nil, 0, 0, 0);

    // Flush with two ops in flight and req1 requesting
    step(mk(1, 0, 3, 3, 4), nil, 0, 0, 0);
    step(nil, mk(1, 0, 5, 5, 9), 0, 0, 0);
    step(nil, mk(1, 0, 2, 2, 11), 0, 1, 0);
    chk("t4_rdy1", 32'(req1_ready_o), 0);
    chk("t4_wbv", 32'(wb_valid_o), 0);
    step(nil, nil, 0, 0, 0);
    chk("t4_mask", pending_rd_mask_o, 0);
    chk("t4_busy", 32'(busy_count_o), 0);
    repeat (3) step(nil, nil, 0, 0, 0);

    // Reset mid-operation; rr_ptr is left at 1 beforehand
    step(mk(1, 0, 2, 3, 12), mk(1, 0, 4, 5, 13), 0, 0, 0);
    step(nil, mk(1, 0, 6, 7, 14), 0, 0, 0);
    step(nil, nil, 0, 0, 1);
    step(nil, nil, 0, 0, 0);
    chk("t5_busy", 32'(busy_count_o), 0);
    chk("t5_mask", pending_rd_mask_o, 0);
    chk("t5_wbv", 32'(wb_valid_o), 0);
    step(mk(1, 0, 8, 8, 15), mk(1, 0, 9, 9, 16), 0, 0, 0);
    chk("t5_gnt0", 32'(req0_ready_o), 1);
    repeat (3) step(nil, nil, 0, 0, 0);

    // rd=0: no hazard bit, writeback still happens
    step(mk(1, 1, 32'hFFFF_FFFB, 3, 0), nil, 0, 0, 0);
    step(nil, nil, 0, 0, 0);
    chk("t6_mask", pending_rd_mask_o, 0);
    step(nil, nil, 0, 0, 0);
    chk("t6_wbv", 32'(wb_valid_o), 1);
    chk("t6_rd", 32'(wb_rd_o), 0);
    repeat (2) step(nil, nil, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r0 = mk($urandom_range(0, 9) < 6, $urandom_range(0, 3), $urandom, $urandom,
              5'($urandom_range(0, 31)));
      r1 = mk($urandom_range(0, 9) < 6, $urandom_range(0, 3), $urandom, $urandom,
              5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) r0.op[14] = 1'b1;
      if ($urandom_range(0, 7) == 0) r1.op[14] = 1'b1;
      st = $urandom_range(0, 99) < 15;
      fl = $urandom_range(0, 99) < 4;
      rs = $urandom_range(0, 99) < 2;
      step(r0, r1, st, fl, rs);
    end

    // Drain: everything issued must have been written back
    repeat (L + 4) step(nil, nil, 0, 0, 0);
    chk("drain_q", 32'(sbq.size()), 0);
    chk("drain_busy", 32'(busy_count_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
